// File: rtl/ads1256_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : ads1256_spi_responder
// Function : ADS1256 command-interface SPI slave with DRDY_L generation;
//            define ADS_EMU_RAMP_EN to source samples from an internal ramp.
// Revision : 1.0
// ============================================================================
module ads1256_spi_responder #(
  parameter int DRDY_PERIOD      = 3333,
  parameter int DRDY_HIGH_CYCLES = 40,
  parameter int SELFCAL_CYCLES   = 8000,
  parameter int NUM_REGS         = 11
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        SCLK_i,
  input  logic        MOSI_i,
  input  logic        CS_L_i,
  input  logic [23:0] conversion_data_i,
  output logic        MISO_o,
  output logic        MISO_oe_o,
  output logic        DRDY_L_o,
  output logic        rdatac_o,
  output logic [7:0]  reg_mux_o
);

  localparam int c_cnt_w = $clog2(DRDY_PERIOD + 1);
  localparam int c_cal_w = $clog2(SELFCAL_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_wrap     = c_cnt_w'(DRDY_PERIOD - 1);
  localparam logic [c_cnt_w-1:0] c_hi_start = c_cnt_w'(DRDY_PERIOD - DRDY_HIGH_CYCLES);
  localparam logic [c_cal_w-1:0] c_cal_end  = c_cal_w'(SELFCAL_CYCLES - 1);
  localparam logic [4:0]         c_num_regs = 5'(NUM_REGS);

  localparam logic [2:0] c_st_cmd      = 3'd0;
  localparam logic [2:0] c_st_rdata    = 3'd1;
  localparam logic [2:0] c_st_rdatac   = 3'd2;
  localparam logic [2:0] c_st_rreg_cnt = 3'd3;
  localparam logic [2:0] c_st_rreg_out = 3'd4;
  localparam logic [2:0] c_st_wreg_cnt = 3'd5;
  localparam logic [2:0] c_st_wreg_in  = 3'd6;
  localparam logic [2:0] c_st_selfcal  = 3'd7;

  function automatic logic [7:0] reg_init(input int idx);
    case (idx)
      0, 1:    reg_init = 8'h01;
      2:       reg_init = 8'h20;
      3:       reg_init = 8'hF0;
      4:       reg_init = 8'hE0;
      10:      reg_init = 8'h40;
      default: reg_init = 8'h00;
    endcase
  endfunction

  logic [1:0]         r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic               r_sclk_prev, r_cs_prev;
  logic [2:0]         r_state;
  logic [2:0]         r_bit_cnt;
  logic [1:0]         r_byte_idx;
  logic [6:0]         r_rx;
  logic [23:0]        r_tx, r_hold;
  logic               r_miso, r_word_act, r_rdatac, r_drdy_l, r_pending;
  logic [4:0]         r_addr;
  logic [3:0]         r_remain;
  logic [c_cnt_w-1:0] r_drdy_cnt;
  logic [c_cal_w-1:0] r_cal_cnt;
  logic [7:0]         r_regs [0:NUM_REGS-1];

  logic        w_cs_act, w_cs_rise, w_sclk_rise, w_sclk_fall, w_byte_done;
  logic        w_busy, w_tx_active, w_wrap, w_do_update, w_cal_done;
  logic [7:0]  w_rx_byte, w_rd_cur, w_rd_nxt;
  logic [4:0]  w_addr_nxt;
  logic [23:0] w_sample;

  // SCLK activity is ignored entirely while self-calibrating.
  assign w_cs_act    = ~r_cs_sync[1];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_prev;
  assign w_sclk_rise = w_cs_act & (r_state != c_st_selfcal) & r_sclk_sync[1] & ~r_sclk_prev;
  assign w_sclk_fall = w_cs_act & (r_state != c_st_selfcal) & ~r_sclk_sync[1] & r_sclk_prev;
  assign w_byte_done = w_sclk_fall & (r_bit_cnt == 3'd0);
  assign w_rx_byte   = {r_rx, r_mosi_sync[1]};
  assign w_busy      = (r_state == c_st_rdata) | ((r_state == c_st_rdatac) & r_word_act);
  assign w_tx_active = w_busy | (r_state == c_st_rreg_out);
  assign w_wrap      = (r_drdy_cnt == c_wrap);
  // A wrap that lands inside a readout is held in r_pending and replayed afterwards.
  assign w_do_update = (w_wrap | r_pending) & ~w_busy & (r_state != c_st_selfcal);
  assign w_cal_done  = (r_state == c_st_selfcal) & (r_cal_cnt == c_cal_end);
  assign w_addr_nxt  = r_addr + 5'd1;

  always_comb begin
    w_rd_cur = 8'h00;
    w_rd_nxt = 8'h00;
    if (r_addr < c_num_regs)     w_rd_cur = r_regs[r_addr[3:0]];
    if (w_addr_nxt < c_num_regs) w_rd_nxt = r_regs[w_addr_nxt[3:0]];
  end

`ifdef ADS_EMU_RAMP_EN
  logic [23:0] r_ramp;
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                        r_ramp <= 24'h123456;
    else if (w_do_update || w_cal_done) r_ramp <= r_ramp + 24'd1;
  end
  assign w_sample = r_ramp;
`else
  assign w_sample = conversion_data_i;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_sclk_sync <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], SCLK_i};
      r_mosi_sync <= {r_mosi_sync[0], MOSI_i};
      r_cs_sync   <= {r_cs_sync[0], CS_L_i};
      r_sclk_prev <= r_sclk_sync[1];
      r_cs_prev   <= r_cs_sync[1];
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= c_st_cmd;
      r_bit_cnt  <= 3'd7;
      r_byte_idx <= 2'd0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_hold     <= '0;
      r_miso     <= 1'b0;
      r_word_act <= 1'b0;
      r_rdatac   <= 1'b0;
      r_drdy_l   <= 1'b1;
      r_pending  <= 1'b0;
      r_addr     <= '0;
      r_remain   <= '0;
      r_drdy_cnt <= '0;
      r_cal_cnt  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= reg_init(i);
    end else begin
      if (r_state == c_st_selfcal || w_wrap) r_drdy_cnt <= '0;
      else                                   r_drdy_cnt <= r_drdy_cnt + c_cnt_w'(1);
      if (r_drdy_cnt == c_hi_start) r_drdy_l <= 1'b1;
      if (w_wrap && w_busy)         r_pending <= 1'b1;

      if (w_do_update) begin
        r_hold    <= w_sample;
        r_drdy_l  <= 1'b0;
        r_pending <= 1'b0;
        if (r_state == c_st_rdatac) begin
          r_tx       <= w_sample;
          r_word_act <= 1'b1;
          r_byte_idx <= 2'd0;
        end
      end

      if (r_state == c_st_selfcal) begin
        r_drdy_l  <= 1'b1;
        r_cal_cnt <= r_cal_cnt + c_cal_w'(1);
        if (w_cal_done) begin
          r_hold   <= w_sample;
          r_drdy_l <= 1'b0;
          r_state  <= c_st_cmd;
        end
      end

      if (w_sclk_rise) begin
        if (w_tx_active) begin
          r_miso <= r_tx[23];
          r_tx   <= {r_tx[22:0], 1'b0};
        end else begin
          r_miso <= 1'b0;
        end
      end

      if (w_sclk_fall) begin
        r_rx      <= w_rx_byte[6:0];
        r_bit_cnt <= r_bit_cnt - 3'd1;
      end

      if (w_byte_done) begin
        case (r_state)
          c_st_cmd: begin
            casez (w_rx_byte)
              8'h01, 8'h03: begin
                r_state    <= c_st_rdata;
                r_tx       <= r_hold;
                r_byte_idx <= 2'd0;
                if (w_rx_byte == 8'h03) r_rdatac <= 1'b1;
              end
              8'h0F: r_rdatac <= 1'b0;
              8'h1?: begin
                r_addr  <= {1'b0, w_rx_byte[3:0]};
                r_state <= c_st_rreg_cnt;
              end
              8'h5?: begin
                r_addr  <= {1'b0, w_rx_byte[3:0]};
                r_state <= c_st_wreg_cnt;
              end
              8'hF0: begin
                r_state   <= c_st_selfcal;
                r_cal_cnt <= '0;
                r_drdy_l  <= 1'b1;
              end
              default: ;
            endcase
          end
          c_st_rdata: begin
            if (r_byte_idx == 2'd2) begin
              r_state    <= r_rdatac ? c_st_rdatac : c_st_cmd;
              r_word_act <= 1'b0;
              r_drdy_l   <= 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end
          c_st_rdatac: begin
            if (r_word_act) begin
              if (r_byte_idx == 2'd0 && w_rx_byte == 8'h0F && !r_drdy_l) begin
                r_rdatac   <= 1'b0;
                r_word_act <= 1'b0;
                r_state    <= c_st_cmd;
              end else if (r_byte_idx == 2'd2) begin
                r_word_act <= 1'b0;
                r_drdy_l   <= 1'b1;
              end else begin
                r_byte_idx <= r_byte_idx + 2'd1;
              end
            end
          end
          c_st_rreg_cnt: begin
            r_remain <= w_rx_byte[3:0];
            r_tx     <= {w_rd_cur, 16'h0000};
            r_state  <= c_st_rreg_out;
          end
          c_st_rreg_out: begin
            if (r_remain == 4'd0) begin
              r_state <= c_st_cmd;
            end else begin
              r_remain <= r_remain - 4'd1;
              r_addr   <= w_addr_nxt;
              r_tx     <= {w_rd_nxt, 16'h0000};
            end
          end
          c_st_wreg_cnt: begin
            r_remain <= w_rx_byte[3:0];
            r_state  <= c_st_wreg_in;
          end
          c_st_wreg_in: begin
            if (r_addr < c_num_regs) r_regs[r_addr[3:0]] <= w_rx_byte;
            r_addr <= w_addr_nxt;
            if (r_remain == 4'd0) r_state <= c_st_cmd;
            else                  r_remain <= r_remain - 4'd1;
          end
          default: r_state <= c_st_cmd;
        endcase
      end

      // Deselect drops any partial byte; calibration runs on regardless of CS.
      if (w_cs_rise) begin
        r_bit_cnt  <= 3'd7;
        r_byte_idx <= 2'd0;
        r_word_act <= 1'b0;
        r_miso     <= 1'b0;
        if (r_state != c_st_selfcal) r_state <= c_st_cmd;
      end
    end
  end

  assign MISO_oe_o = w_cs_act;
  assign MISO_o    = w_cs_act & r_miso;
  assign DRDY_L_o  = r_drdy_l;
  assign rdatac_o  = r_rdatac;
  assign reg_mux_o = r_regs[1];

endmodule
`default_nettype wire

// File: tb/tb_ads1256_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ads1256_spi_responder
// Function : Randomized self-checking bench for ads1256_spi_responder against
//            a register-array / data-word reference model.
// Revision : 1.0
// ============================================================================
module tb_ads1256_spi_responder;

  localparam int P = 1000;
  localparam int H = 40;
  localparam int S = 1500;
  localparam int N = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_l = 1'b1;
  logic [23:0] conv = 24'h123456;
  logic        miso, oe, drdy_l, rdatac;
  logic [7:0]  reg_mux;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  m_regs [0:N-1];
  logic [7:0]  b, d;
  logic [23:0] w, exp_w;
  logic [3:0]  a;
  int          n, cnt;
  logic        drdy_at_sample;

  ads1256_spi_responder #(
    .DRDY_PERIOD     (P),
    .DRDY_HIGH_CYCLES(H),
    .SELFCAL_CYCLES  (S),
    .NUM_REGS        (N)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .SCLK_i           (sclk),
    .MOSI_i           (mosi),
    .CS_L_i           (cs_l),
    .conversion_data_i(conv),
    .MISO_o           (miso),
    .MISO_oe_o        (oe),
    .DRDY_L_o         (drdy_l),
    .rdatac_o         (rdatac),
    .reg_mux_o        (reg_mux)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_reset();
    logic [7:0] init [0:N-1];
    init = '{8'h01, 8'h01, 8'h20, 8'hF0, 8'hE0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
    for (int i = 0; i < N; i++) m_regs[i] = init[i];
  endfunction

  function automatic logic [7:0] m_read(input int addr);
    return (addr < N) ? m_regs[addr] : 8'h00;
  endfunction

  function automatic void m_write(input int addr, input logic [7:0] v);
    if (addr < N) m_regs[addr] = v;
  endfunction

  // CPOL=0/CPHA=1 master, SCLK = clk/16: drive on rise, sample MISO before fall.
  task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      @(negedge clk);
      mosi = tx[i];
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      rx[i] = miso;
      drdy_at_sample = drdy_l;
      sclk = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic read_word(output logic [23:0] word);
    logic [7:0] b0, b1, b2;
    xfer(8'h00, b0);
    xfer(8'h00, b1);
    xfer(8'h00, b2);
    word = {b0, b1, b2};
  endtask

  task automatic cs_on();
    @(negedge clk);
    cs_l = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_off();
    repeat (4) @(negedge clk);
    cs_l = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_drdy_fall();
    int t = 0;
    while (drdy_l !== 1'b1 && t < 3 * P) begin @(negedge clk); t++; end
    while (drdy_l !== 1'b0 && t < 3 * P) begin @(negedge clk); t++; end
    check("drdy_wait_timeout", 32'(t >= 3 * P), 32'd0);
  endtask

  task automatic do_rdata(input string tag, input logic [23:0] expect_word);
    logic [7:0]  bb;
    logic [23:0] ww;
    cs_on();
    xfer(8'h01, bb);
    read_word(ww);
    check(tag, 32'(ww), 32'(expect_word));
    check("drdy_low_before_last_bit", 32'(drdy_at_sample), 32'd0);
    check("drdy_high_after_word", 32'(drdy_l), 32'd1);
    cs_off();
  endtask

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_drdy", 32'(drdy_l), 32'd1);
    check("rst_rdatac", 32'(rdatac), 32'd0);
    check("rst_reg_mux", 32'(reg_mux), 32'h01);
    rst = 1'b0;

    // Single RDATA of a fixed sample
    wait_drdy_fall();
    cs_on();
    check("oe_when_selected", 32'(oe), 32'd1);
    cs_off();
    do_rdata("rdata_word", 24'h123456);

    // Continuous read across three conversions, then SDATAC
    conv = 24'hA5A5A5;
    wait_drdy_fall();
    cs_on();
    xfer(8'h03, b);
    read_word(w);
    check("rdatac_word0", 32'(w), 32'hA5A5A5);
    check("rdatac_flag_set", 32'(rdatac), 32'd1);
    conv = 24'h5A5A5A;
    wait_drdy_fall();
    read_word(w);
    check("rdatac_word1", 32'(w), 32'h5A5A5A);
    conv = 24'h000001;
    wait_drdy_fall();
    read_word(w);
    check("rdatac_word2", 32'(w), 32'h000001);
    check("rdatac_flag_held", 32'(rdatac), 32'd1);
    conv = 24'($urandom);
    exp_w = conv;
    wait_drdy_fall();
    xfer(8'h0F, b);
    check("sdatac_first_byte", 32'(b), 32'(exp_w[23:16]));
    check("sdatac_flag_clear", 32'(rdatac), 32'd0);
    xfer(8'h00, b);
    xfer(8'h00, b);
    wait_drdy_fall();
    read_word(w);
    check("no_output_after_sdatac", 32'(w), 32'd0);
    cs_off();

    // Directed WREG / RREG
    cs_on();
    xfer(8'h51, b); xfer(8'h01, b); xfer(8'h23, b); xfer(8'h45, b);
    cs_off();
    m_write(1, 8'h23);
    m_write(2, 8'h45);
    cs_on();
    xfer(8'h11, b); xfer(8'h01, b);
    xfer(8'h00, b); check("rreg_0x01", 32'(b), 32'(m_read(1)));
    xfer(8'h00, b); check("rreg_0x02", 32'(b), 32'(m_read(2)));
    cs_off();
    check("reg_mux_after_wreg", 32'(reg_mux), 32'(m_read(1)));

    // Out-of-range read and dropped writes
    cs_on();
    xfer(8'h19, b); xfer(8'h03, b);
    for (int k = 0; k < 4; k++) begin
      xfer(8'h00, b);
      check("rreg_oor", 32'(b), 32'(m_read(9 + k)));
    end
    cs_off();
    cs_on();
    xfer(8'h5C, b); xfer(8'h03, b);
    for (int k = 0; k < 4; k++) xfer(8'($urandom), b);
    cs_off();
    cs_on();
    xfer(8'h10, b); xfer(8'h0F, b);
    for (int k = 0; k < 16; k++) begin
      xfer(8'h00, b);
      check("dump_after_oor_wreg", 32'(b), 32'(m_read(k)));
    end
    cs_off();

    // Randomized register traffic
    for (int it = 0; it < 8; it++) begin
      a = 4'($urandom_range(0, 15));
      n = $urandom_range(0, 5);
      cs_on();
      xfer({4'h5, a}, b);
      xfer(8'(n), b);
      for (int k = 0; k <= n; k++) begin
        d = 8'($urandom);
        xfer(d, b);
        m_write(int'(a) + k, d);
      end
      cs_off();
      a = 4'($urandom_range(0, 15));
      n = $urandom_range(0, 5);
      cs_on();
      xfer({4'h1, a}, b);
      xfer(8'(n), b);
      for (int k = 0; k <= n; k++) begin
        xfer(8'h00, b);
        check("rreg_random", 32'(b), 32'(m_read(int'(a) + k)));
      end
      cs_off();
      check("reg_mux_random", 32'(reg_mux), 32'(m_read(1)));
    end

    // Randomized RDATA samples
    for (int it = 0; it < 3; it++) begin
      conv = 24'($urandom);
      exp_w = conv;
      wait_drdy_fall();
      do_rdata("rdata_random", exp_w);
    end

    // Self-calibration with an ignored SPI burst in the middle
    conv = 24'($urandom);
    exp_w = conv;
    cs_on();
    xfer(8'hF0, b);
    check("selfcal_drdy_high", 32'(drdy_l), 32'd1);
    fork
      begin
        cnt = 0;
        while (drdy_l !== 1'b0 && cnt < 3 * S) begin @(negedge clk); cnt++; end
      end
      begin
        cs_off();
        cs_on();
        xfer(8'h51, b); xfer(8'h00, b); xfer(8'h77, b);
        cs_off();
      end
    join
    if (cnt < S - 16 || cnt > S + 4) $display("FAIL selfcal_len: got %0d expected about %0d", cnt, S);
    check("selfcal_len_in_window", 32'(cnt >= S - 16 && cnt <= S + 4), 32'd1);
    check("selfcal_burst_ignored", 32'(reg_mux), 32'(m_read(1)));
    do_rdata("selfcal_fresh_data", exp_w);

    // CS abort in the middle of a readout
    conv = 24'($urandom);
    wait_drdy_fall();
    cs_on();
    xfer(8'h01, b);
    spi_bits(8'h00, 4, b);
    cs_off();
    check("abort_oe", 32'(oe), 32'd0);
    check("abort_miso", 32'(miso), 32'd0);
    cs_on();
    xfer(8'h11, b); xfer(8'h00, b); xfer(8'h00, b);
    check("cmd_after_abort", 32'(b), 32'(m_read(1)));
    cs_off();

    // Reset in the middle of RREG
    cs_on();
    xfer(8'h10, b); xfer(8'h05, b);
    spi_bits(8'h00, 4, b);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_miso", 32'(miso), 32'd0);
    check("midrst_oe", 32'(oe), 32'd0);
    check("midrst_drdy", 32'(drdy_l), 32'd1);
    check("midrst_rdatac", 32'(rdatac), 32'd0);
    check("midrst_reg_mux", 32'(reg_mux), 32'h01);
    model_reset();
    cs_l = 1'b1;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    cs_on();
    xfer(8'h10, b); xfer(8'h0A, b);
    for (int k = 0; k < N; k++) begin
      xfer(8'h00, b);
      check("dump_after_reset", 32'(b), 32'(m_read(k)));
    end
    cs_off();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
